// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_BURST_LEN  = 4;

  // Beat counter width; a one-beat burst still needs a 1-bit counter.
  function automatic int cnt_width(input int burst_len);
    return ($clog2(burst_len) < 1) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping by explicit compare so non-power-of-two counts work.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_rr_ptr,
  output logic                     o_found,
  output logic [$clog2(N_REQ)-1:0] o_index
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] N_S = SW'(N_REQ);

  logic [SW-1:0] w_sum;
  logic [IW-1:0] w_cand;

  // Scan N_REQ candidates upward from the pointer; the first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum   = {1'b0, i_rr_ptr} + SW'(k);
      w_sum   = (w_sum >= N_S) ? (w_sum - N_S) : w_sum;
      w_cand  = w_sum[IW-1:0];
      o_index = (!o_found && i_req[w_cand]) ? w_cand : o_index;
      o_found = o_found | i_req[w_cand];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling N_REQ write requesters into one
// shared synchronous FIFO; one idle bubble separates consecutive grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(N_REQ - 1);

  arb_state_e      r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_grant_id;
  logic [CW-1:0]   r_beat_cnt;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_gnt_valid;
  logic            w_accept_ok;
  logic            w_wr;
  logic [IW-1:0]   w_next_ptr;
  logic [DATA_WIDTH-1:0] w_words [N_REQ];

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_index  (w_pick)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Writes are suppressed during the reset cycle so an abandoned burst never leaks a beat.
  assign w_gnt_valid = req_valid[r_grant_id];
  assign w_accept_ok = (r_state == BURST) && !fifo_full && !rst;
  assign w_wr        = w_accept_ok && w_gnt_valid;
  assign w_next_ptr  = (r_grant_id == LAST_REQ) ? '0 : (r_grant_id + IW'(1));

  // Only the granted requester may see ready.
  always_comb begin
    req_ready             = '0;
    req_ready[r_grant_id] = w_accept_ok;
  end

  assign fifo_wr_en   = w_wr;
  assign fifo_data_in = w_words[r_grant_id];
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == BURST);

  // Grant FSM: pick in IDLE, count beats in BURST, release on last beat or dropped valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end else begin
            r_state    <= IDLE;
          end
        end
        BURST: begin
          if (!w_gnt_valid) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (!fifo_full) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end else begin
            r_state <= BURST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level model
// plus a queue-based FIFO that checks read order.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic [1:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: owner = requester holding the grant (-1 when idle),
  // taken = beats already written in this grant, ptr = next search start.
  int owner = -1;
  int taken = 0;
  int ptr   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom_range(0, 255));
  endtask

  // One clock: compare outputs at the falling edge, then advance model and FIFO.
  task automatic run_cycle(input logic pop_en);
    logic [N-1:0]  e_ready;
    logic          e_wr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    int            sel;
    fifo_full = (fifo_q.size() >= DEPTH);
    @(negedge clk);
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (owner >= 0 && !rst && !fifo_full) e_ready[owner] = 1'b1;
    if (owner >= 0 && !rst && !fifo_full && req_valid[owner]) begin
      e_wr   = 1'b1;
      e_data = req_data[owner*DW +: DW];
    end
    check_eq("busy", 32'(busy), 32'(owner >= 0));
    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    if (owner >= 0) check_eq("grant_id", 32'(grant_id), 32'(owner));
    if (e_wr) check_eq("fifo_data_in", 32'(fifo_data_in), 32'(e_data));

    // FIFO: read happens at the same edge as the write.
    if (pop_en && fifo_q.size() > 0) begin
      got = fifo_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check_eq("fifo_read_order", 32'(got), 32'(want));
    end
    if (fifo_wr_en) fifo_q.push_back(fifo_data_in);
    if (e_wr) exp_q.push_back(e_data);

    if (rst) begin
      owner = -1;
      ptr   = 0;
      taken = 0;
    end else if (owner < 0) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && req_valid[(ptr + k) % N]) sel = (ptr + k) % N;
      end
      owner = sel;
      taken = 0;
    end else if (!req_valid[owner]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end else if (!fifo_full) begin
      taken++;
      if (taken == BL) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    fifo_full = 1'b0;
    randomize_data();
    @(posedge clk);
    #1;

    // Reset held with every requester valid.
    for (int c = 0; c < 2; c++) begin
      randomize_data();
      run_cycle(1'b1);
    end

    // All valid, FIFO drained every cycle: plain round-robin bursts.
    rst = 1'b0;
    for (int c = 0; c < 26; c++) begin
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'hA0 + i);
      run_cycle(1'b1);
    end

    // Early release: only requester 2, two beats, then valid drops.
    rst = 1'b1;
    run_cycle(1'b1);
    rst = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      randomize_data();
      run_cycle(1'b1);
    end
    req_valid = 4'b0000;
    run_cycle(1'b1);
    run_cycle(1'b1);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      randomize_data();
      run_cycle(1'b1);
    end

    // Full stall: stop draining so the FIFO fills mid-burst, then resume.
    for (int c = 0; c < 12; c++) begin
      randomize_data();
      run_cycle(c >= 8);
    end

    // Random traffic with FIFO back-pressure and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) req_valid[i] = ~req_valid[i];
      end
      rst = ($urandom_range(0, 63) == 0);
      randomize_data();
      run_cycle($urandom_range(0, 1) == 1);
    end

    // Drain what is left in the FIFO.
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 0; c < DEPTH + 4; c++) run_cycle(1'b1);
    check_eq("fifo_drained", 32'(fifo_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each write data word.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of write requesters (legal range 2..16).
REQ-003 The block SHALL have parameter BURST_LEN, default 4, giving the maximum number of beats accepted per grant (legal range 1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, N_REQ bits: bit i high means requester i presents a word.
REQ-007 The block SHALL have port req_data, input, N_REQ*DATA_WIDTH bits: requester i's word occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: bit i high means requester i's word is accepted this cycle if its valid is high.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: the full flag from the shared synchronous FIFO.
REQ-010 The block SHALL have port fifo_wr_en, output, 1 bit: write enable to the FIFO w_en.
REQ-011 The block SHALL have port fifo_data_in, output, DATA_WIDTH bits: write data to the FIFO data_in.
REQ-012 The block SHALL have port grant_id, output, $clog2(N_REQ) bits: the index of the requester currently granted.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BURST.

Function
REQ-014 The block SHALL have two states, IDLE and BURST, held in a registered state variable.
REQ-015 In IDLE with any req_valid bit high, the block SHALL select the first valid index found scanning upward from rr_ptr, wrapping modulo N_REQ, register it into grant_id, clear beat_cnt, and enter BURST on the next edge.
REQ-016 In IDLE, req_ready and fifo_wr_en SHALL be 0; arbitration latency from valid to first possible accept is exactly one cycle.
REQ-017 In BURST, req_ready[grant_id] SHALL equal !fifo_full and all other req_ready bits SHALL be 0 (combinational).
REQ-018 In BURST, fifo_wr_en SHALL equal req_valid[grant_id] & !fifo_full, and fifo_data_in SHALL equal requester grant_id's slice; no write is ever issued while fifo_full is high.
REQ-019 Each accepted beat (fifo_wr_en high) SHALL increment beat_cnt; beat_cnt has width max(1,$clog2(BURST_LEN)).
REQ-020 The grant SHALL be released, returning to IDLE, on the edge where a beat is accepted with beat_cnt == BURST_LEN-1, or in any BURST cycle where req_valid[grant_id] is low.
REQ-021 On release, rr_ptr SHALL become (grant_id+1) mod N_REQ; one idle bubble cycle always separates consecutive grants.
REQ-022 A fifo_full stall SHALL hold the grant, beat_cnt and state unchanged, with no timeout.
REQ-023 Requesters whose valid rises while another holds the grant SHALL wait; a requester valid continuously SHALL be granted within N_REQ-1 other grants (starvation-free).
REQ-024 When N_REQ is not a power of two, rr_ptr wrap SHALL be by explicit compare to N_REQ-1, never by bit truncation.

Reset
REQ-025 When rst is high at a clock edge: state SHALL become IDLE, rr_ptr 0, grant_id 0 and beat_cnt 0; busy, fifo_wr_en and req_ready SHALL then be 0; fifo_data_in is don't-care.
REQ-026 Reset asserted mid-burst SHALL abandon the burst with no further write, and no write SHALL be issued in the cycle rst is high.

Structure
REQ-027 The state enum typedef (IDLE, BURST) and default parameter constants SHALL live in package fifo_arb_pkg.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, rr_ptr; outputs: found, index), instantiated once.

Verification
REQ-029 Reset: rst=1 for 2 cycles with all valids high -> busy=0, fifo_wr_en=0, req_ready=0; after release, first grant goes to requester 0.
REQ-030 Round robin: valid=4'b1111 held, BURST_LEN=4, fifo never full -> grant order 0,1,2,3,0; 4 writes per grant; 1 bubble between grants.
REQ-031 Early release: only requester 2 valid for 2 beats, then low -> 2 writes, return to IDLE, rr_ptr=3.
REQ-032 Full stall: fifo_full high for 3 cycles mid-burst on requester 1 -> fifo_wr_en=0 and req_ready=0 for those cycles; grant_id stays 1; burst totals 4 writes.
REQ-033 Reset mid-burst: rst at beat 2 of requester 3 -> no write in the reset cycle, next grant is requester 0.
REQ-034 Data integrity: with the FIFO instantiated, words 8'hA0+i from requester i -> FIFO read order matches grant order, no overflow assertion fires.
